// File: rtl/reset_sequencer.sv
// reset_sequencer: staged startup/soft reset sequencer with ready filtering and a ready-loss counter.
//
// Ports:
//   clock_i              system clock (single domain)
//   reset_i              asynchronous active-high reset
//   ready_i              readiness inputs, 1 = ready
//   ready_mask_i         1 = ignore the corresponding ready_i
//   soft_reset_i         soft reset request, level sampled every clock
//   stage_reset_o        per-stage active-high resets, released in order from stage 0
//   all_released_o       1 once every stage reset is released
//   soft_reset_pending_o soft reset delay is running
//   ready_drop_cnt_o     saturating count of ready losses seen while sequencing or running
//   state_o              0 = WAIT_READY, 1 = SEQUENCE, 2 = RUN
module reset_sequencer #(
    parameter int NUM_READY     = 4,
    parameter int NUM_STAGES    = 2,
    parameter int CNT_BITS      = 18,
    parameter logic [NUM_STAGES*CNT_BITS-1:0] STAGE_CNTS = {18'd262143, 18'd31},
    parameter int READY_FILTER  = 8,
    parameter int SOFT_DELAY    = 1023,
    parameter int SOFT_BITS     = 10,
    parameter int DROP_CNT_BITS = 8
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic [NUM_READY-1:0]     ready_i,
    input  logic [NUM_READY-1:0]     ready_mask_i,
    input  logic                     soft_reset_i,
    output logic [NUM_STAGES-1:0]    stage_reset_o,
    output logic                     all_released_o,
    output logic                     soft_reset_pending_o,
    output logic [DROP_CNT_BITS-1:0] ready_drop_cnt_o,
    output logic [1:0]               state_o
);

    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_STAGES - 1);
    localparam logic [CNT_BITS-1:0] FILT_END = CNT_BITS'(READY_FILTER - 1);
    localparam logic [SOFT_BITS-1:0] SDLY_LOAD = SOFT_BITS'(SOFT_DELAY);

    typedef enum logic [1:0] {
        WAIT_READY = 2'd0,
        SEQUENCE   = 2'd1,
        RUN        = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [NUM_READY-1:0]     ready_q, ready_d;
    logic [CNT_BITS-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [NUM_STAGES-1:0]    stage_q, stage_d;
    logic                     all_rel_q, all_rel_d;
    logic [SOFT_BITS-1:0]     sdly_q, sdly_d;
    logic                     pend_q, pend_d;
    logic [DROP_CNT_BITS-1:0] drop_q, drop_d;

    logic                     all_ok;
    logic [CNT_BITS-1:0]      hold;
    logic                     loss;
    logic                     expire;

    assign all_ok = &(ready_q | ready_mask_i);
    assign hold   = STAGE_CNTS[idx_q*CNT_BITS +: CNT_BITS];

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= WAIT_READY;
            ready_q   <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            stage_q   <= '1;
            all_rel_q <= 1'b0;
            sdly_q    <= '0;
            pend_q    <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            stage_q   <= stage_d;
            all_rel_q <= all_rel_d;
            sdly_q    <= sdly_d;
            pend_q    <= pend_d;
            drop_q    <= drop_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ready_d   = ready_i;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        stage_d   = stage_q;
        all_rel_d = all_rel_q;
        sdly_d    = sdly_q;
        pend_d    = pend_q;
        drop_d    = drop_q;
        loss      = 1'b0;
        expire    = 1'b0;
        case (state_q)
            WAIT_READY: begin
                if (!all_ok) begin
                    cnt_d = '0;
                end else if (cnt_q == FILT_END) begin
                    state_d = SEQUENCE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_BITS'(1);
                end
            end
            SEQUENCE: begin
                if (!all_ok) begin
                    loss = 1'b1;
                end else if (cnt_q == hold) begin
                    stage_d[idx_q] = 1'b0;
                    cnt_d          = '0;
                    idx_d          = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d   = RUN;
                        all_rel_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_BITS'(1);
                end
            end
            RUN: begin
                loss = !all_ok;
            end
            default: begin
                state_d = WAIT_READY;
            end
        endcase
        // A request on the would-be expiry edge reloads instead of firing.
        if (soft_reset_i) begin
            sdly_d = SDLY_LOAD;
            pend_d = 1'b1;
        end else if (sdly_q != '0) begin
            sdly_d = sdly_q - SOFT_BITS'(1);
            expire = (sdly_q == SOFT_BITS'(1));
        end
        if (loss && (drop_q != '1)) begin
            drop_d = drop_q + DROP_CNT_BITS'(1);
        end
        // Loss and expiry share the same restart; both may hit on one edge.
        if (loss || expire) begin
            state_d   = WAIT_READY;
            stage_d   = '1;
            cnt_d     = '0;
            all_rel_d = 1'b0;
        end
        if (expire) begin
            pend_d = 1'b0;
        end
    end

    assign stage_reset_o        = stage_q;
    assign all_released_o       = all_rel_q;
    assign soft_reset_pending_o = pend_q;
    assign ready_drop_cnt_o     = drop_q;
    assign state_o              = state_q;

endmodule
